// File: rtl/alu_op_sequencer.sv
// Execute/writeback sequencer for the mini CPU data_path.
// Accepts one register-register or unary ALU instruction. It then steps through
// LOAD_Y, EXEC, WB_LO, WB_HI and DONE, one state per cycle, and drives the
// data_path strobes from the current state and the captured instruction fields.
// State changes on the falling edge of Clock, so the strobes are stable across
// the data_path rising edge.
// Optional feature macro: SEQ_R0_WRITE_GUARD_EN. When it is defined, narrow
// writebacks to R0 are suppressed.
module alu_op_sequencer #(
   parameter logic [4:0] MUL_OP = 5'b01111,
   parameter logic [4:0] DIV_OP = 5'b10000,
   parameter logic [4:0] NEG_OP = 5'b10001,
   parameter logic [4:0] NOT_OP = 5'b10010
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  op_in,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   input  logic [3:0]  rc,
   output logic        ready,
   output logic        done,
   output logic [4:0]  op,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        Yin,
   output logic        ZHighin,
   output logic        Zlowin,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        HIin,
   output logic        LOin
);

   typedef enum logic [2:0] {
      StIdle,
      StLoadY,
      StExec,
      StWbLo,
      StWbHi,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] op_q;
   logic [3:0] ra_q, rb_q, rc_q;

   logic in_unary;
   logic cap_unary;
   logic cap_wide;

   assign in_unary  = (op_in == NEG_OP) || (op_in == NOT_OP);
   assign cap_unary = (op_q == NEG_OP) || (op_q == NOT_OP);
   assign cap_wide  = (op_q == MUL_OP) || (op_q == DIV_OP);

   // State register and instruction capture; fields are latched only on acceptance in IDLE.
   always_ff @(negedge Clock or negedge clear) begin
      if (!clear) begin
         state_q <= StIdle;
         op_q    <= 5'd0;
         ra_q    <= 4'd0;
         rb_q    <= 4'd0;
         rc_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && start) begin
            op_q <= op_in;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
         end
      end
   end

   // Next-state selection; unary ops skip the Y load, wide ops add a HI writeback.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = in_unary ? StExec : StLoadY;
            end
         end
         StLoadY: state_d = StExec;
         StExec:  state_d = StWbLo;
         StWbLo:  state_d = cap_wide ? StWbHi : StDone;
         StWbHi:  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Strobe decode from state and captured fields only; at most one bus driver per state.
   always_comb begin
      ready    = 1'b0;
      done     = 1'b0;
      op       = 5'd0;
      Rout     = 16'h0000;
      Rin      = 16'h0000;
      Yin      = 1'b0;
      ZHighin  = 1'b0;
      Zlowin   = 1'b0;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      case (state_q)
         StIdle: ready = 1'b1;
         StLoadY: begin
            Rout[rb_q] = 1'b1;
            Yin        = 1'b1;
         end
         StExec: begin
            op      = op_q;
            ZHighin = 1'b1;
            Zlowin  = 1'b1;
            if (cap_unary) begin
               Rout[rb_q] = 1'b1;
            end else begin
               Rout[rc_q] = 1'b1;
            end
         end
         StWbLo: begin
            Zlowout = 1'b1;
            if (cap_wide) begin
               LOin = 1'b1;
            end else begin
`ifdef SEQ_R0_WRITE_GUARD_EN
               // R0 is treated as read-only; the sequence timing is unchanged.
               if (ra_q != 4'd0) begin
                  Rin[ra_q] = 1'b1;
               end
`else
               Rin[ra_q] = 1'b1;
`endif
            end
         end
         StWbHi: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         StDone: done = 1'b1;
         default: ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer.
// The driver predicts each accepted instruction's per-cycle strobe pattern and
// pushes it into a queue. The monitor compares every sampled cycle against the
// queue head, or against the idle pattern when the queue is empty.
module tb_alu_op_sequencer;

   localparam logic [4:0] MUL_OP = 5'b01111;
   localparam logic [4:0] DIV_OP = 5'b10000;
   localparam logic [4:0] NEG_OP = 5'b10001;
   localparam logic [4:0] NOT_OP = 5'b10010;
   localparam logic [4:0] ADD_OP = 5'b00011;

   typedef struct packed {
      logic        ready;
      logic        done;
      logic [4:0]  op;
      logic [15:0] rout;
      logic [15:0] rin;
      logic        yin;
      logic        zhin;
      logic        zlin;
      logic        zhout;
      logic        zlout;
      logic        hiin;
      logic        loin;
   } vec_t;

   logic        Clock;
   logic        clear;
   logic        start;
   logic [4:0]  op_in;
   logic [3:0]  ra, rb, rc;
   logic        ready, done;
   logic [4:0]  op;
   logic [15:0] Rout, Rin;
   logic        Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin;

   vec_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rem     = 0;

   alu_op_sequencer dut (
      .Clock    (Clock),
      .clear    (clear),
      .start    (start),
      .op_in    (op_in),
      .ra       (ra),
      .rb       (rb),
      .rc       (rc),
      .ready    (ready),
      .done     (done),
      .op       (op),
      .Rout     (Rout),
      .Rin      (Rin),
      .Yin      (Yin),
      .ZHighin  (ZHighin),
      .Zlowin   (Zlowin),
      .Zhighout (Zhighout),
      .Zlowout  (Zlowout),
      .HIin     (HIin),
      .LOin     (LOin)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic vec_t idle_vec();
      vec_t v;
      v       = '0;
      v.ready = 1'b1;
      return v;
   endfunction

   function automatic vec_t sample_dut();
      vec_t v;
      v.ready = ready;
      v.done  = done;
      v.op    = op;
      v.rout  = Rout;
      v.rin   = Rin;
      v.yin   = Yin;
      v.zhin  = ZHighin;
      v.zlin  = Zlowin;
      v.zhout = Zhighout;
      v.zlout = Zlowout;
      v.hiin  = HIin;
      v.loin  = LOin;
      return v;
   endfunction

   task automatic check(input string name, input vec_t act, input vec_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference: the cycle list an instruction should produce, derived from its op class.
   task automatic push_expected(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, output int len);
      vec_t v;
      logic unary, wide;
      unary = (o == NEG_OP) || (o == NOT_OP);
      wide  = (o == MUL_OP) || (o == DIV_OP);
      len   = 0;
      if (!unary) begin
         v = '0; v.rout = 16'h0001 << b; v.yin = 1'b1;
         exp_q.push_back(v); len++;
      end
      v = '0; v.op = o; v.zhin = 1'b1; v.zlin = 1'b1;
      v.rout = 16'h0001 << (unary ? b : c);
      exp_q.push_back(v); len++;
      v = '0; v.zlout = 1'b1;
      if (wide) begin
         v.loin = 1'b1;
      end else begin
         v.rin = 16'h0001 << a;
`ifdef SEQ_R0_WRITE_GUARD_EN
         if (a == 4'd0) v.rin = 16'h0000;
`endif
      end
      exp_q.push_back(v); len++;
      if (wide) begin
         v = '0; v.zhout = 1'b1; v.hiin = 1'b1;
         exp_q.push_back(v); len++;
      end
      v = '0; v.done = 1'b1;
      exp_q.push_back(v); len++;
   endtask

   // Monitor: sample half a cycle away from the falling state edge.
   always @(posedge Clock) begin
      #1;
      if (exp_q.size() != 0) begin
         check("seq_cycle", sample_dut(), exp_q.pop_front());
      end else begin
         check("idle", sample_dut(), idle_vec());
      end
   end

   // One driving slot; the model accepts only when it has returned to idle.
   task automatic cycle_drive(input logic s, input logic [4:0] o, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] c);
      int len;
      @(posedge Clock);
      #2;
      if (rem > 0) rem--;
      start = s;
      op_in = o;
      ra    = a;
      rb    = b;
      rc    = c;
      if (clear && s && rem == 0) begin
         push_expected(o, a, b, c, len);
         rem = len + 1;
      end
   endtask

   task automatic do_reset();
      clear = 1'b0;
      start = 1'b0;
      exp_q.delete();
      rem = 0;
      #1;
      check("reset_async", sample_dut(), idle_vec());
      @(posedge Clock);
      #2;
      clear = 1'b1;
   endtask

   function automatic logic [4:0] rand_op();
      case ($urandom_range(0, 5))
         0: return MUL_OP;
         1: return DIV_OP;
         2: return NEG_OP;
         3: return NOT_OP;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      clear = 1'b0;
      start = 1'b0;
      op_in = 5'd0;
      ra    = 4'd0;
      rb    = 4'd0;
      rc    = 4'd0;
      repeat (2) @(posedge Clock);
      #2;
      clear = 1'b1;

      // ADD interrupted by clear while in EXEC, then a clean restart.
      cycle_drive(1'b1, ADD_OP, 4'd1, 4'd2, 4'd3);
      cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
      @(posedge Clock);
      #2;
      do_reset();
      cycle_drive(1'b1, ADD_OP, 4'd9, 4'd10, 4'd11);
      repeat (6) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);

      // Directed: binary narrow, MUL, DIV, NEG, NOT, ADD to R0.
      cycle_drive(1'b1, ADD_OP, 4'd1, 4'd2, 4'd3);
      repeat (6) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
      cycle_drive(1'b1, MUL_OP, 4'd0, 4'd4, 4'd5);
      repeat (7) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
      cycle_drive(1'b1, DIV_OP, 4'd3, 4'd14, 4'd15);
      repeat (7) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
      cycle_drive(1'b1, NEG_OP, 4'd7, 4'd6, 4'd1);
      repeat (5) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
      cycle_drive(1'b1, NOT_OP, 4'd15, 4'd12, 4'd2);
      repeat (5) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
      cycle_drive(1'b1, ADD_OP, 4'd0, 4'd2, 4'd3);
      repeat (6) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);

      // start held high with changing fields: only the first IDLE edge accepts.
      for (int i = 0; i < 14; i++) begin
         cycle_drive(1'b1, (i % 3 == 1) ? MUL_OP : 5'(i), 4'(i), 4'(i + 3), 4'(15 - i));
      end
      repeat (6) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);

      // Randomized traffic with occasional asynchronous clear.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            @(posedge Clock);
            #2;
            do_reset();
         end else begin
            cycle_drive(1'($urandom_range(0, 1)), rand_op(), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         end
      end
      repeat (8) cycle_drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
      @(posedge Clock);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control sequencer for the mini CPU data_path. It accepts one register-register or unary ALU instruction and drives the one-hot register out/in strobes, Yin, ZHighin/Zlowin, Zhighout/Zlowout, HIin/LOin and the ALU op code, one state per cycle. It replaces hand-written per-state stimulus with a reusable execute/writeback controller. It sits between instruction decode (start/op/ra/rb/rc) and data_path.

Parameters:
MUL_OP, 5'b01111, op code whose 64-bit result goes to HI/LO.
DIV_OP, 5'b10000, op code whose result goes to HI (remainder) and LO (quotient).
NEG_OP, 5'b10001, unary op; no Y load.
NOT_OP, 5'b10010, unary op; no Y load.

Ports:
Clock  in  1  system clock; sequencer state advances on the falling edge.
clear  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only when ready=1.
op_in  in  5  ALU op code to execute.
ra  in  4  destination register index.
rb  in  4  first source register index (the only source for unary ops).
rc  in  4  second source register index.
ready  out  1  high in IDLE only.
done  out  1  one-cycle pulse in DONE state.
op  out  5  ALU op to data_path; captured op in EXEC, else 0.
Rout  out  16  one-hot register-out strobes (bit n = Rnout).
Rin  out  16  one-hot register-in strobes (bit n = Rnin).
Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin  out  1 each  data_path strobes.

Behaviour:
- States: IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE. Encoded state register updates on negedge Clock, so strobes are stable across the data_path rising edge. All outputs decode from the state and the captured fields only.
- Reset (clear=0, asynchronous): state=IDLE. Captured op/ra/rb/rc=0. All strobes=0, op=0, done=0, ready=1. This applies at any point, including mid-sequence. Nothing is written back.
- IDLE: ready=1. If start=1 at a falling edge, capture op_in/ra/rb/rc. Next state is EXEC for NEG_OP/NOT_OP, else LOAD_Y. Otherwise stay.
- LOAD_Y: Rout[rb]=1, Yin=1. Next: EXEC.
- EXEC: op=captured op, ZHighin=1, Zlowin=1. Rout[rc]=1 for binary ops, Rout[rb]=1 for unary ops. Next: WB_LO.
- WB_LO: Zlowout=1. For MUL_OP/DIV_OP, LOin=1 and next is WB_HI. Otherwise Rin[ra]=1 and next is DONE.
- WB_HI: Zhighout=1, HIin=1. Next: DONE.
- DONE: done=1. Next: IDLE. start is not accepted in DONE.
- Latency from the accepting edge to done high: binary narrow 4 cycles, unary 3 cycles, MUL/DIV 5 cycles. Back-to-back issue costs one extra IDLE cycle.
- start while ready=0 is ignored. Input fields are don't-care after capture.
- Invariants:
  - At most one Rout bit and at most one Rin bit high.
  - Never two bus drivers in the same cycle (Rout, Zhighout, Zlowout are mutually exclusive).
  - Rin is never high in the same state as any Rout bit.
  - op=0 outside EXEC.
- Ops other than MUL/DIV/NEG/NOT are treated as binary narrow. No op-code validation.
- Unused strobes (MDRout, PCout, InPortout, etc.) are not driven by this block.

Optional Feature:
SEQ_R0_WRITE_GUARD_EN
- Defined: in WB_LO with ra=0 on a narrow op, Rin stays 0, so R0 is never written and reads as its prior value. The sequence and done timing are unchanged.
- Undefined: Rin[0]=1 as normal.

Test Plan:
1. clear=0 asserted mid-EXEC of an ADD -> within the same cycle all strobes 0, op=0, ready=1. After clear=1, an idle start proceeds normally.
2. start with op_in=5'b00011, ra=1, rb=2, rc=3 -> the following cycles occur:
   - LOAD_Y: Rout=16'h0004, Yin=1.
   - EXEC: Rout=16'h0008, op=5'b00011, ZHighin=Zlowin=1.
   - WB_LO: Zlowout=1, Rin=16'h0002.
   - DONE: done=1.
   - Then ready=1.
3. MUL_OP with rb=4, rc=5 -> LOAD_Y Rout=16'h0010; EXEC Rout=16'h0020; WB_LO Zlowout+LOin; WB_HI Zhighout+HIin; done in the 5th cycle; Rin=0 throughout.
4. NEG_OP with rb=6, ra=7 -> no LOAD_Y (Yin never 1); EXEC Rout=16'h0040, op=5'b10001; WB_LO Rin=16'h0080; done in the 3rd cycle.
5. start held high during an active sequence with changing op_in/ra -> the in-flight writeback still targets the originally captured ra. The second instruction is accepted only at the first IDLE edge.
6. ADD with ra=0 -> WB_LO Rin=16'h0000 with SEQ_R0_WRITE_GUARD_EN defined, Rin=16'h0001 without. done timing is identical in both builds.
